// File: rtl/confirm_resolve_engine.sv
// confirm_resolve_engine: pipelined segment-wise confirmation of SDRAM TCAM candidates,
// best-priority resolution and hit counting, one result per start/end-delimited search.
`default_nettype none

module confirm_resolve_engine #(
  parameter int DATA_BITS = 10,
  parameter int MASKWID   = 5,
  parameter int IDWID     = 2,
  parameter int PRIOWID   = 2,
  parameter int CNTWID    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_search_start,
  input  logic [DATA_BITS-1:0] i_key,
  input  logic                 i_cand_valid,
  output logic                 o_cand_ready,
  input  logic [IDWID-1:0]     i_cand_id,
  input  logic [MASKWID-1:0]   i_cand_mask,
  input  logic [PRIOWID-1:0]   i_cand_priority,
  input  logic [DATA_BITS-1:0] i_cand_key,
  input  logic                 i_search_end,
  output logic                 o_busy,
  output logic                 o_result_valid,
  output logic                 o_result_hit,
  output logic [IDWID-1:0]     o_result_id,
  output logic [PRIOWID-1:0]   o_result_priority,
  output logic [CNTWID-1:0]    o_hit_count
);

  localparam int SEGW = DATA_BITS / MASKWID;
  localparam logic [CNTWID-1:0] CNT_MAX = {CNTWID{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   drain_cnt;

  logic start_ok;
  logic accept;

  logic [DATA_BITS-1:0] key_q;

  logic                 s1_valid;
  logic [IDWID-1:0]     s1_id;
  logic [MASKWID-1:0]   s1_mask;
  logic [PRIOWID-1:0]   s1_prio;
  logic [DATA_BITS-1:0] s1_key;
  logic [MASKWID-1:0]   match_vec;

  logic                 s2_valid;
  logic [IDWID-1:0]     s2_id;
  logic [PRIOWID-1:0]   s2_prio;
  logic [MASKWID-1:0]   s2_match;
  logic                 s3_hit;

  logic                 best_valid;
  logic [IDWID-1:0]     best_id;
  logic [PRIOWID-1:0]   best_prio;
  logic [CNTWID-1:0]    hit_cnt;

  assign o_busy       = (state != IDLE);
  assign o_cand_ready = (state == SEARCH);
  assign start_ok     = i_search_start && (state == IDLE);
  assign accept       = i_cand_valid && o_cand_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : 1'b0;
    end
  end

  // DRAIN lasts two cycles so the last accepted candidate clears stage 3 before DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_search_start) state_nxt = SEARCH;
      SEARCH:  if (i_search_end) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q <= '0;
    end else if (start_ok) begin
      key_q <= i_key;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_mask  <= '0;
      s1_prio  <= '0;
      s1_key   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_id   <= i_cand_id;
        s1_mask <= i_cand_mask;
        s1_prio <= i_cand_priority;
        s1_key  <= i_cand_key;
      end
    end
  end

  for (genvar g = 0; g < MASKWID; g++) begin : g_seg
    assign match_vec[g] = s1_mask[g] || (s1_key[SEGW*g +: SEGW] == key_q[SEGW*g +: SEGW]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_prio  <= '0;
      s2_match <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_prio  <= s1_prio;
      s2_match <= match_vec;
    end
  end

  assign s3_hit = s2_valid && (&s2_match);

  // Strict less-than keeps the earlier candidate on a priority tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_valid <= 1'b0;
      best_id    <= '0;
      best_prio  <= '0;
      hit_cnt    <= '0;
    end else if (start_ok) begin
      best_valid <= 1'b0;
      best_id    <= '0;
      best_prio  <= '0;
      hit_cnt    <= '0;
    end else if (s3_hit) begin
      if (!best_valid || (s2_prio < best_prio)) begin
        best_valid <= 1'b1;
        best_id    <= s2_id;
        best_prio  <= s2_prio;
      end
      if (hit_cnt != CNT_MAX) begin
        hit_cnt <= hit_cnt + CNTWID'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_result_valid    <= 1'b0;
      o_result_hit      <= 1'b0;
      o_result_id       <= '0;
      o_result_priority <= '0;
      o_hit_count       <= '0;
    end else begin
      o_result_valid <= (state == DONE);
      if (state == DONE) begin
        o_result_hit      <= best_valid;
        o_result_id       <= best_id;
        o_result_priority <= best_prio;
        o_hit_count       <= hit_cnt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_confirm_resolve_engine.sv
// Self-checking bench for confirm_resolve_engine: directed scenarios plus randomized
// searches checked against a list-based reference model (main instance and a 2-bit-counter instance).
`default_nettype none

module tb_confirm_resolve_engine;

  localparam int DB   = 10;
  localparam int MW   = 5;
  localparam int IW   = 2;
  localparam int PW   = 2;
  localparam int CW   = 4;
  localparam int SEGW = DB / MW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_search_start = 1'b0;
  logic [DB-1:0] i_key = '0;
  logic          i_cand_valid = 1'b0;
  logic [IW-1:0] i_cand_id = '0;
  logic [MW-1:0] i_cand_mask = '0;
  logic [PW-1:0] i_cand_priority = '0;
  logic [DB-1:0] i_cand_key = '0;
  logic          i_search_end = 1'b0;

  logic          o_cand_ready, o_busy, o_result_valid, o_result_hit;
  logic [IW-1:0] o_result_id;
  logic [PW-1:0] o_result_priority;
  logic [CW-1:0] o_hit_count;

  logic          s_cand_ready, s_busy, s_result_valid, s_result_hit;
  logic [IW-1:0] s_result_id;
  logic [PW-1:0] s_result_priority;
  logic [1:0]    s_hit_count;

  confirm_resolve_engine #(.DATA_BITS(DB), .MASKWID(MW), .IDWID(IW), .PRIOWID(PW), .CNTWID(CW)) dut (
    .clk(clk), .reset(reset), .i_search_start(i_search_start), .i_key(i_key),
    .i_cand_valid(i_cand_valid), .o_cand_ready(o_cand_ready), .i_cand_id(i_cand_id),
    .i_cand_mask(i_cand_mask), .i_cand_priority(i_cand_priority), .i_cand_key(i_cand_key),
    .i_search_end(i_search_end), .o_busy(o_busy), .o_result_valid(o_result_valid),
    .o_result_hit(o_result_hit), .o_result_id(o_result_id),
    .o_result_priority(o_result_priority), .o_hit_count(o_hit_count));

  confirm_resolve_engine #(.DATA_BITS(DB), .MASKWID(MW), .IDWID(IW), .PRIOWID(PW), .CNTWID(2)) dut_sat (
    .clk(clk), .reset(reset), .i_search_start(i_search_start), .i_key(i_key),
    .i_cand_valid(i_cand_valid), .o_cand_ready(s_cand_ready), .i_cand_id(i_cand_id),
    .i_cand_mask(i_cand_mask), .i_cand_priority(i_cand_priority), .i_cand_key(i_cand_key),
    .i_search_end(i_search_end), .o_busy(s_busy), .o_result_valid(s_result_valid),
    .o_result_hit(s_result_hit), .o_result_id(s_result_id),
    .o_result_priority(s_result_priority), .o_hit_count(s_hit_count));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Candidates accepted in the current search, and the key it was opened with.
  int ncand;
  int c_id[64], c_mask[64], c_prio[64], c_key[64];
  int skey;

  // Captured DUT result.
  int   lat;
  logic g_hit, g_busy, g_after;
  int   g_id, g_prio, g_cnt, g_cnt2;

  // Expected result.
  bit e_hit;
  int e_id, e_prio, e_cnt;

  task automatic begin_search(input int k);
    i_search_start = 1'b1;
    i_key = DB'(k);
    skey = k;
    ncand = 0;
    @(posedge clk); #1;
    i_search_start = 1'b0;
  endtask

  task automatic send_cand(input int id, input int mask, input int prio, input int ck, input bit with_end);
    i_cand_valid = 1'b1;
    i_cand_id = IW'(id);
    i_cand_mask = MW'(mask);
    i_cand_priority = PW'(prio);
    i_cand_key = DB'(ck);
    i_search_end = with_end;
    c_id[ncand] = id; c_mask[ncand] = mask; c_prio[ncand] = prio; c_key[ncand] = ck;
    ncand++;
    @(posedge clk); #1;
    i_cand_valid = 1'b0;
    i_search_end = 1'b0;
  endtask

  task automatic send_end();
    i_search_end = 1'b1;
    @(posedge clk); #1;
    i_search_end = 1'b0;
  endtask

  // Counts edges after the end edge until the result pulse (99 on timeout).
  task automatic wait_result();
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (o_result_valid) begin
        lat = i;
        break;
      end
    end
    g_hit = o_result_hit; g_id = int'(o_result_id); g_prio = int'(o_result_priority);
    g_cnt = int'(o_hit_count); g_cnt2 = int'(s_hit_count); g_busy = o_busy;
    @(posedge clk); #1;
    g_after = o_result_valid;
  endtask

  // Reference: a candidate hits when every unmasked segment equals the search key segment;
  // the first candidate holding the smallest priority wins; count saturates at cmax.
  task automatic model(input int cmax);
    int seg_a, seg_b;
    bit m;
    e_hit = 0; e_id = 0; e_prio = 0; e_cnt = 0;
    for (int i = 0; i < ncand; i++) begin
      m = 1;
      for (int s = 0; s < MW; s++) begin
        seg_a = (c_key[i] >> (s * SEGW)) % (1 << SEGW);
        seg_b = (skey >> (s * SEGW)) % (1 << SEGW);
        if (((c_mask[i] >> s) % 2 == 0) && seg_a != seg_b) m = 0;
      end
      if (m) begin
        e_cnt++;
        if (!e_hit || c_prio[i] < e_prio) begin
          e_hit = 1; e_id = c_id[i]; e_prio = c_prio[i];
        end
      end
    end
    if (e_cnt > cmax) e_cnt = cmax;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({o_result_valid, o_result_hit, o_result_id, o_result_priority, o_hit_count} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0",
        {o_result_valid, o_result_hit, o_result_id, o_result_priority, o_hit_count});
    end
    total++;
    if ({o_busy, o_cand_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_busy_ready: got %b want 00", {o_busy, o_cand_ready});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_exact_match();
    begin_search('h2A5);
    send_cand(1, 0, 2, 'h2A5, 1'b0);
    send_end();
    wait_result();
    total++;
    if (lat !== 3) begin bad++; $display("FAIL exact_latency: got %0d want 3", lat); end
    total++;
    if ({g_hit, 2'(g_id), 2'(g_prio), 4'(g_cnt)} !== {1'b1, 2'd1, 2'd2, 4'd1}) begin
      bad++; $display("FAIL exact_result: got hit=%0d id=%0d prio=%0d cnt=%0d want 1 1 2 1",
        g_hit, g_id, g_prio, g_cnt);
    end
    total++;
    if ({g_busy, g_after} !== 2'b00) begin
      bad++; $display("FAIL exact_busy_pulse: got busy=%0d next_valid=%0d want 0 0", g_busy, g_after);
    end
  endtask

  task automatic test_masking();
    begin_search('h3FF);
    send_cand(2, 'b11111, 1, 'h000, 1'b1);
    wait_result();
    total++;
    if (g_hit !== 1'b1) begin bad++; $display("FAIL mask_all_hit: got %0d want 1", g_hit); end
    begin_search('h3FF);
    send_cand(2, 'b11110, 1, 'h000, 1'b1);
    wait_result();
    total++;
    if ({g_hit, 2'(g_id), 4'(g_cnt)} !== 7'b0) begin
      bad++; $display("FAIL mask_seg0_miss: got hit=%0d id=%0d cnt=%0d want 0 0 0", g_hit, g_id, g_cnt);
    end
  endtask

  task automatic test_back_to_back_priority();
    begin_search('h155);
    send_cand(0, 0, 3, 'h155, 1'b0);
    send_cand(2, 0, 1, 'h155, 1'b0);
    send_cand(3, 0, 1, 'h155, 1'b1);
    wait_result();
    total++;
    if ({2'(g_id), 2'(g_prio), 4'(g_cnt)} !== {2'd2, 2'd1, 4'd3} || lat !== 3) begin
      bad++; $display("FAIL priority_tie: got id=%0d prio=%0d cnt=%0d lat=%0d want 2 1 3 3",
        g_id, g_prio, g_cnt, lat);
    end
  endtask

  task automatic test_empty_ignored();
    i_cand_valid = 1'b1; i_cand_key = DB'('h155); i_cand_mask = '0; i_cand_id = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (o_cand_ready !== 1'b0) begin bad++; $display("FAIL idle_ready: got %0d want 0", o_cand_ready); end
    i_cand_valid = 1'b0;
    begin_search('h155);
    send_end();
    wait_result();
    total++;
    if ({g_hit, 4'(g_cnt), lat[3:0]} !== {1'b0, 4'd0, 4'd3}) begin
      bad++; $display("FAIL empty_search: got hit=%0d cnt=%0d lat=%0d want 0 0 3", g_hit, g_cnt, lat);
    end
    begin_search('h155);
    i_search_start = 1'b1; i_key = DB'('h2AA);
    @(posedge clk); #1;
    i_search_start = 1'b0;
    total++;
    if (o_busy !== 1'b1) begin bad++; $display("FAIL restart_busy: got %0d want 1", o_busy); end
    send_cand(2, 0, 1, 'h155, 1'b0);
    send_cand(1, 0, 0, 'h2AA, 1'b1);
    wait_result();
    model(15);
    total++;
    if ({g_hit, 2'(g_id), 4'(g_cnt)} !== {e_hit, 2'(e_id), 4'(e_cnt)}) begin
      bad++; $display("FAIL restart_key_kept: got hit=%0d id=%0d cnt=%0d want %0d %0d %0d",
        g_hit, g_id, g_cnt, e_hit, e_id, e_cnt);
    end
  endtask

  task automatic test_saturation();
    begin_search('h0F0);
    for (int i = 0; i < 5; i++) send_cand(i % 4, 0, 3 - (i % 4), 'h0F0, i == 4);
    wait_result();
    total++;
    if ({s_result_hit, g_cnt2[1:0]} !== {1'b1, 2'd3}) begin
      bad++; $display("FAIL sat_cnt2: got hit=%0d cnt=%0d want 1 3", s_result_hit, g_cnt2);
    end
    total++;
    if (g_cnt !== 5) begin bad++; $display("FAIL sat_cnt4_unsat: got %0d want 5", g_cnt); end
    begin_search('h0F0);
    for (int i = 0; i < 20; i++) send_cand(1, 'b00001, 2, 'h0F3, i == 19);
    wait_result();
    total++;
    if (g_cnt !== 15) begin bad++; $display("FAIL sat_cnt4: got %0d want 15", g_cnt); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    begin_search('h1C3);
    send_cand(2, 0, 1, 'h1C3, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    total++;
    if ({o_busy, o_result_valid, o_result_hit, o_result_id, o_result_priority, o_hit_count} !== '0) begin
      bad++; $display("FAIL reset_mid_outputs: got %b want 0",
        {o_busy, o_result_valid, o_result_hit, o_result_id, o_result_priority, o_hit_count});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (o_result_valid) seen = 1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL reset_mid_no_pulse: got %0d want 0", seen); end
    begin_search('h0AB);
    send_cand(3, 0, 2, 'h0AB, 1'b1);
    wait_result();
    total++;
    if ({g_hit, 2'(g_id), lat[3:0]} !== {1'b1, 2'd3, 4'd3}) begin
      bad++; $display("FAIL reset_mid_recover: got hit=%0d id=%0d lat=%0d want 1 3 3", g_hit, g_id, lat);
    end
  endtask

  task automatic test_random();
    int n, k, ck, sel;
    bit last_end;
    for (int it = 0; it < 12; it++) begin
      k = int'($urandom_range(0, 1023));
      n = int'($urandom_range(0, 8));
      last_end = $urandom_range(0, 1) == 1;
      begin_search(k);
      for (int i = 0; i < n; i++) begin
        sel = int'($urandom_range(0, 2));
        ck = (sel == 0) ? k : (sel == 1) ? (k ^ (1 << $urandom_range(0, DB - 1))) : int'($urandom_range(0, 1023));
        send_cand(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : 0,
                  int'($urandom_range(0, 3)), ck, last_end && (i == n - 1));
      end
      if (!last_end || n == 0) send_end();
      wait_result();
      model(15);
      total++;
      if ({g_hit, 2'(g_id), 2'(g_prio), 4'(g_cnt)} !== {e_hit, 2'(e_id), 2'(e_prio), 4'(e_cnt)} || lat != 3) begin
        bad++; $display("FAIL rand_%0d: got hit=%0d id=%0d prio=%0d cnt=%0d lat=%0d want %0d %0d %0d %0d 3",
          it, g_hit, g_id, g_prio, g_cnt, lat, e_hit, e_id, e_prio, e_cnt);
      end
      model(3);
      total++;
      if (g_cnt2 !== e_cnt) begin
        bad++; $display("FAIL rand_sat_%0d: got cnt=%0d want %0d", it, g_cnt2, e_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact_match();
    test_masking();
    test_back_to_back_priority();
    test_empty_ignored();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
